// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide unit, also used by the decoder
// and hazard logic.
//   XLEN_DEFAULT : default operand/result width
//   F3_*         : func_3 encodings of the four divide/remainder ops
//   div_state_t  : divide FSM state encoding
package div_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational iteration of a restoring divide.
//   rem_i  : partial remainder (XLEN+1 bits)
//   bit_i  : next dividend bit, shifted in at the LSB
//   div_i  : divisor magnitude
//   rem_o  : next partial remainder
//   q_o    : quotient bit produced by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_o
);

  logic [XLEN+1:0] partial;
  logic [XLEN+1:0] divisor_ext;

  always_comb begin
    partial     = {rem_i, bit_i};
    divisor_ext = (XLEN+2)'(div_i);
    // No borrow on the trial subtract <=> partial >= divisor.
    q_o         = (partial >= divisor_ext);
    rem_o       = (XLEN+1)'(q_o ? (partial - divisor_ext) : partial);
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU).
//   clk, rst : clock and synchronous active-high reset
//   start    : request strobe, accepted only when not busy
//   func_3   : 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_1     : dividend (rs1)
//   op_2     : divisor (rs2)
//   busy     : high while iterating
//   done     : one-cycle pulse, result valid in that cycle
//   result   : quotient or remainder, held until the next accepted start
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func_3,
  input  logic [XLEN-1:0] op_1,
  input  logic [XLEN-1:0] op_2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  div_state_t        state_q,  state_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [XLEN:0]     rem_q,    rem_d;
  logic [XLEN-1:0]   quo_q,    quo_d;
  logic [XLEN-1:0]   dvsr_q,   dvsr_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_q,    neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  logic [XLEN:0]     step_rem;
  logic              step_q;

  logic              signed_op;
  logic              op1_neg;
  logic              op2_neg;
  logic              overflow;
  logic [XLEN-1:0]   quo_next;
  logic [XLEN-1:0]   final_val;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[XLEN-1]),
    .div_i (dvsr_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    is_rem_d = is_rem_q;
    neg_d    = neg_q;
    result_d = result_q;

    signed_op = ~func_3[0];
    op1_neg   = signed_op & op_1[XLEN-1];
    op2_neg   = signed_op & op_2[XLEN-1];
    overflow  = signed_op && (op_1 == {1'b1, {(XLEN-1){1'b0}}}) && (op_2 == '1);

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the MSB while quotient bits enter at the LSB.
    quo_next  = {quo_q[XLEN-2:0], step_q};
    final_val = is_rem_q ? step_rem[XLEN-1:0] : quo_next;

    case (state_q)
      CALC: begin
        rem_d   = step_rem;
        quo_d   = quo_next;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(XLEN - 1)) begin
          state_d  = DONE;
          result_d = neg_q ? -final_val : final_val;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        state_d = IDLE;
        if (start) begin
          state_d = DONE;
          if (!func_3[2]) begin
            result_d = '0;
          end else if (op_2 == '0) begin
            result_d = func_3[1] ? op_1 : '1;
          end else if (overflow) begin
            result_d = func_3[1] ? '0 : op_1;
          end else begin
            state_d  = CALC;
            count_d  = '0;
            rem_d    = '0;
            quo_d    = op1_neg ? -op_1 : op_1;
            dvsr_d   = op2_neg ? -op_2 : op_2;
            is_rem_d = func_3[1];
            neg_d    = func_3[1] ? op1_neg : (op1_neg ^ op2_neg);
          end
        end
      end
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      is_rem_q <= is_rem_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  func_3;
  logic [31:0] op_1;
  logic [31:0] op_2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func_3 (func_3),
    .op_1   (op_1),
    .op_2   (op_2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done, check latency, busy span and result.
  // Returns just after the edge that raised done (inside the DONE cycle).
  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
    int lat;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; func_3 = f; op_1 = a; op_2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_lat"}, 32'(lat), 32'(lat_exp));
    chk({nm, "_busycycles"}, 32'(busy_cnt), 32'((lat_exp > 1) ? lat_exp - 1 : 0));
    chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({nm, "_result"}, result, exp);
  endtask

  initial begin
    int lat;
    int done_seen;

    vecs[0]  = '{"divu_100_7",     3'b101, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{"remu_100_7",     3'b111, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{"div_m7_2",       3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{"rem_m7_2",       3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{"rem_7_m2",       3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[5]  = '{"div_7_m2",       3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[6]  = '{"divu_5_0",       3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{"remu_5_0",       3'b111, 32'd5,          32'd0,          32'd5,          1};
    vecs[8]  = '{"rem_m7_0",       3'b110, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};
    vecs[9]  = '{"div_ovf",        3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[10] = '{"rem_ovf",        3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[11] = '{"not_divide",     3'b000, 32'd100,        32'd7,          32'd0,          1};
    vecs[12] = '{"divu_ovfpair",   3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[13] = '{"remu_ovfpair",   3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
    vecs[14] = '{"div_min_2",      3'b100, 32'h8000_0000,  32'd2,          32'hC000_0000,  33};
    vecs[15] = '{"div_m8_m3",      3'b100, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          33};
    vecs[16] = '{"rem_m8_m3",      3'b110, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  33};
    vecs[17] = '{"divu_hex",       3'b101, 32'h1234_5678,  32'h0000_1000,  32'h0001_2345,  33};

    rst = 1'b1; start = 1'b0; func_3 = 3'b000; op_1 = '0; op_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      @(posedge clk); #1;
      chk({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
    end

    // Back-to-back: second start lands in the first op's DONE cycle.
    do_op("b2b_first", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    do_op("b2b_second", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    @(posedge clk); #1;

    // Start during CALC is ignored and the held result stays put.
    @(negedge clk);
    start = 1'b1; func_3 = 3'b101; op_1 = 32'd100; op_2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (2) begin @(posedge clk); #1; lat++; end
    chk("ign_result_held", result, 32'hFFFF_FFFF);
    @(negedge clk);
    start = 1'b1; func_3 = 3'b111; op_1 = 32'd1000; op_2 = 32'd3;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_lat", 32'(lat), 32'd33);
    chk("ign_result", result, 32'd14);
    @(posedge clk); #1;

    // Reset at cycle 10 of CALC aborts the op with no done.
    @(negedge clk);
    start = 1'b1; func_3 = 3'b101; op_1 = 32'd100; op_2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    chk("rst_no_done", 32'(done_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
